seq_match_ctrl: RTL and testbench

- Programmable serial-pattern match controller for single-bit input streams.
- Holds pattern, mask and target-count configuration, and arms/disarms matching under software/host control.
- Runs an overlapping shift-register matcher and counts matches.
- Stops and flags completion after a target number of hits; sits between a serial bit source and a host/status interface.

---
 rtl/seq_match_ctrl.sv | 96 +++++++++
 tb/tb_seq_match_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: armed overlapping serial-pattern matcher with saturating hit counter and target stop
module seq_match_ctrl #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] RST_PAT = 4'b0110
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [PAT_W-1:0] cfg_mask,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             busy,
   output logic             done,
   output logic             sat
);
   localparam int FW = $clog2(PAT_W + 1);
   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
   state_t state, state_n;
   logic [PAT_W-1:0] pattern, pattern_n, mask, mask_n, history, history_n, nh;
   logic [CNT_W-1:0] target, target_n, count_n, cnt_inc;
   logic [FW-1:0] fill, fill_n;
   logic match_n, sat_n, full, hit;
   assign nh      = {history[PAT_W-2:0], bit_in};
   assign full    = fill >= FW'(PAT_W - 1);
   assign hit     = state == ARMED && bit_valid && !abort && full && ((nh ^ pattern) & mask) == '0;
   assign cnt_inc = (match_count == '1) ? match_count : match_count + 1'b1;
   assign busy    = state == ARMED;
   assign done    = state == DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pattern     <= RST_PAT;
         mask        <= '1;
         target      <= '0;
         history     <= '0;
         fill        <= '0;
         match       <= 1'b0;
         match_count <= '0;
         sat         <= 1'b0;
      end else begin
         state       <= state_n;
         pattern     <= pattern_n;
         mask        <= mask_n;
         target      <= target_n;
         history     <= history_n;
         fill        <= fill_n;
         match       <= match_n;
         match_count <= count_n;
         sat         <= sat_n;
      end
   end
   always_comb begin
      state_n   = state;
      pattern_n = pattern;
      mask_n    = mask;
      target_n  = target;
      history_n = history;
      fill_n    = fill;
      count_n   = match_count;
      sat_n     = sat;
      match_n   = 1'b0;
      if (abort) begin
         state_n = IDLE;
      end else begin
         if (state == IDLE && cfg_we) begin
            pattern_n = cfg_pattern;
            mask_n    = cfg_mask;
            target_n  = cfg_target;
         end
         if (state != ARMED && start) begin
            state_n   = ARMED;
            history_n = '0;
            fill_n    = '0;
            count_n   = '0;
            sat_n     = 1'b0;
         end
         if (state == ARMED && bit_valid) begin
            history_n = nh;
            fill_n    = full ? FW'(PAT_W) : fill + 1'b1;
         end
         if (hit) begin
            match_n = 1'b1;
            count_n = cnt_inc;
            sat_n   = sat | (cnt_inc == '1);
            if (target != '0 && cnt_inc == target) state_n = DONE;
         end
      end
   end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed bench with an expected-match queue for seq_match_ctrl
module tb_seq_match_ctrl;
   logic clk = 0, rst = 1, cfg_we = 0, start = 0, abort = 0, bit_valid = 0, bit_in = 0;
   logic [3:0] cfg_pattern = '0, cfg_mask = '0;
   logic [7:0] cfg_target = '0;
   logic match, busy, done, sat, match2, busy2, done2, sat2;
   logic [7:0] match_count;
   logic [1:0] match_count2;
   int errors = 0, checks = 0;
   logic exp_q[$];
   always #5 clk = ~clk;
   seq_match_ctrl dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .cfg_target(cfg_target), .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
      .match(match), .match_count(match_count), .busy(busy), .done(done), .sat(sat)
   );
   seq_match_ctrl #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b0110)) dut2 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .cfg_target(cfg_target[1:0]), .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
      .match(match2), .match_count(match_count2), .busy(busy2), .done(done2), .sat(sat2)
   );
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic b, input logic e);
      bit_valid = 1;
      bit_in = b;
      exp_q.push_back(e);
      tick();
      bit_valid = 0;
      chk("match", {7'd0, match}, {7'd0, exp_q.pop_front()});
   endtask
   task automatic stream(input logic [7:0] bits, input logic [7:0] exp, input int n);
      for (int i = n - 1; i >= 0; i--) send(bits[i], exp[i]);
   endtask
   task automatic cfg_start(input logic [3:0] p, input logic [3:0] m, input logic [7:0] t);
      abort = 1;
      tick();
      abort = 0;
      cfg_we = 1;
      cfg_pattern = p;
      cfg_mask = m;
      cfg_target = t;
      start = 1;
      tick();
      cfg_we = 0;
      start = 0;
   endtask
   initial begin
      #2;
      chk("rst_match", {7'd0, match}, 8'd0);
      chk("rst_count", match_count, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_sat", {7'd0, sat}, 8'd0);
      tick();
      rst = 0;
      start = 1;
      tick();
      start = 0;
      chk("t1_busy", {7'd0, busy}, 8'd1);
      stream(8'b0110110, 8'b0001001, 7);
      tick();
      chk("t1_match_low", {7'd0, match}, 8'd0);
      chk("t1_count", match_count, 8'd2);
      chk("t1_busy2", {7'd0, busy}, 8'd1);
      chk("t1_done", {7'd0, done}, 8'd0);
      cfg_start(4'b0000, 4'b1111, 8'd3);
      chk("t2_count0", match_count, 8'd0);
      stream(8'b000000, 8'b000111, 6);
      chk("t2_done", {7'd0, done}, 8'd1);
      chk("t2_busy", {7'd0, busy}, 8'd0);
      chk("t2_count", match_count, 8'd3);
      stream(8'b00, 8'b00, 2);
      chk("t2_count_hold", match_count, 8'd3);
      chk("t2_done_hold", {7'd0, done}, 8'd1);
      cfg_start(4'b1001, 4'b1001, 8'd0);
      stream(8'b1111, 8'b0001, 4);
      chk("t3_count", match_count, 8'd1);
      cfg_start(4'b1001, 4'b1001, 8'd0);
      stream(8'b1010, 8'b0000, 4);
      chk("t3_nohit", match_count, 8'd0);
      cfg_start(4'b0110, 4'b1111, 8'd0);
      stream(8'b011011, 8'b000100, 6);
      abort = 1;
      bit_valid = 1;
      bit_in = 0;
      tick();
      abort = 0;
      bit_valid = 0;
      chk("t4_match", {7'd0, match}, 8'd0);
      chk("t4_count", match_count, 8'd1);
      chk("t4_busy", {7'd0, busy}, 8'd0);
      send(1'b0, 1'b0);
      chk("t4_idle_count", match_count, 8'd1);
      cfg_start(4'b0000, 4'b0000, 8'd0);
      stream(8'hA5, 8'b00011111, 8);
      chk("t5_count", match_count, 8'd5);
      chk("t5_sat", {7'd0, sat}, 8'd0);
      chk("t5_count2", {6'd0, match_count2}, 8'd3);
      chk("t5_sat2", {7'd0, sat2}, 8'd1);
      chk("t5_busy2", {7'd0, busy2}, 8'd1);
      chk("t5_done2", {7'd0, done2}, 8'd0);
      cfg_start(4'b0000, 4'b1111, 8'd0);
      stream(8'b00000, 8'b00011, 5);
      chk("t6_count", match_count, 8'd2);
      #2 rst = 1;
      #1;
      chk("t6_rst_match", {7'd0, match}, 8'd0);
      chk("t6_rst_count", match_count, 8'd0);
      chk("t6_rst_busy", {7'd0, busy}, 8'd0);
      @(posedge clk);
      #1 rst = 0;
      start = 1;
      tick();
      start = 0;
      chk("t6_busy", {7'd0, busy}, 8'd1);
      cfg_we = 1;
      cfg_pattern = 4'b1111;
      cfg_mask = 4'b1111;
      stream(8'b0110, 8'b0001, 4);
      cfg_we = 0;
      chk("t6_count_after", match_count, 8'd1);
      chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
